// File: rtl/dca_matrix_lsu_rdata_unformatter_if.sv
// Bus interface for the DCA matrix LSU read-data unformatter.
// Groups the three handshake channels: transaction info, AXI R beats and
// unformatted LSU element rows. The slave modport is the unformatter's view.
interface dca_matrix_lsu_rdata_unformatter_if #(
    parameter int NUM_COL    = 4,
    parameter int BW_SCALAR  = 8,
    parameter int BW_ELEMENT = 32,
    parameter int BW_ALEN    = 8
);
    logic                            txn_valid;
    logic                            txn_ready;
    logic [BW_ALEN-1:0]              txn_alen;
    logic                            txn_is_signed;
    logic [NUM_COL-1:0]              txn_col_mask;
    logic                            txn_is_last;

    logic                            rdata_valid;
    logic                            rdata_ready;
    logic [NUM_COL*BW_SCALAR-1:0]    rdata_data;
    logic                            rdata_last;

    logic                            row_valid;
    logic                            row_ready;
    logic [NUM_COL*BW_ELEMENT-1:0]   row_data;
    logic                            row_last;

    modport slave (
        input  txn_valid, txn_alen, txn_is_signed, txn_col_mask, txn_is_last,
        output txn_ready,
        input  rdata_valid, rdata_data, rdata_last,
        output rdata_ready,
        output row_valid, row_data, row_last,
        input  row_ready
    );

    modport master (
        output txn_valid, txn_alen, txn_is_signed, txn_col_mask, txn_is_last,
        input  txn_ready,
        output rdata_valid, rdata_data, rdata_last,
        input  rdata_ready,
        input  row_valid, row_data, row_last,
        output row_ready
    );
endinterface

// File: rtl/dca_matrix_lsu_rdata_unformatter.sv
// DCA matrix LSU read-data unformatter.
// Queues per-transaction info, splits each AXI R beat into NUM_COL scalars,
// sign/zero-extends them to BW_ELEMENT, zeroes masked columns and presents
// the row through a registered valid/ready stage.
// Optional: define DCA_RDATA_UNFORMAT_RLAST_CHECK_EN to add a sticky
// err_rlast flag comparing RLAST against the alen-derived burst end.
module dca_matrix_lsu_rdata_unformatter #(
    parameter int NUM_COL    = 4,
    parameter int BW_SCALAR  = 8,
    parameter int BW_ELEMENT = 32,
    parameter int BW_ALEN    = 8,
    parameter int TXN_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    dca_matrix_lsu_rdata_unformatter_if.slave bus,
    output logic [$clog2(TXN_DEPTH):0]   txn_count,
`ifdef DCA_RDATA_UNFORMAT_RLAST_CHECK_EN
    output logic                         err_rlast,
`endif
    output logic                         busy
);
    localparam int PW = $clog2(TXN_DEPTH);

    // transaction-info FIFO storage
    logic [BW_ALEN-1:0] alen_mem   [TXN_DEPTH];
    logic               signed_mem [TXN_DEPTH];
    logic [NUM_COL-1:0] mask_mem   [TXN_DEPTH];
    logic               last_mem   [TXN_DEPTH];

    // pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW:0] wr_ptr, rd_ptr, count;
    logic        full, nonempty, push, pop;

    logic [BW_ALEN-1:0] beat_cnt;
    logic [BW_ALEN-1:0] head_alen;
    logic               head_signed, head_last, at_end, beat_acc;
    logic [NUM_COL-1:0] head_mask;

    logic                                  row_valid_q, row_last_q;
    logic [NUM_COL-1:0][BW_ELEMENT-1:0]    row_q, next_row;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (PW+1)'(TXN_DEPTH));
    assign nonempty = (count != '0);
    // ready deliberately ignores a same-cycle pop
    assign push     = bus.txn_valid & ~full;

    assign head_alen   = alen_mem[rd_ptr[PW-1:0]];
    assign head_signed = signed_mem[rd_ptr[PW-1:0]];
    assign head_mask   = mask_mem[rd_ptr[PW-1:0]];
    assign head_last   = last_mem[rd_ptr[PW-1:0]];

    assign bus.rdata_ready = nonempty & (~row_valid_q | bus.row_ready);
    assign beat_acc        = bus.rdata_valid & bus.rdata_ready;
    assign at_end          = (beat_cnt == head_alen);
    assign pop             = beat_acc & at_end;

    assign bus.txn_ready = ~full;
    assign bus.row_valid = row_valid_q;
    assign bus.row_data  = row_q;
    assign bus.row_last  = row_last_q;
    assign txn_count     = count;
    assign busy          = nonempty | row_valid_q;

    // per-column extraction, extension and masking
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        logic [BW_SCALAR-1:0] s;
        assign s = bus.rdata_data[BW_SCALAR*c +: BW_SCALAR];
        if (BW_ELEMENT == BW_SCALAR) begin : g_pass
            assign next_row[c] = head_mask[c] ? s : '0;
        end else begin : g_ext
            logic ext;
            assign ext = head_signed & s[BW_SCALAR-1];
            assign next_row[c] = head_mask[c] ? {{(BW_ELEMENT-BW_SCALAR){ext}}, s} : '0;
        end
    end

    // FIFO payload write; no reset needed, occupancy is tracked by pointers
    always_ff @(posedge clk) begin
        if (push) begin
            alen_mem[wr_ptr[PW-1:0]]   <= bus.txn_alen;
            signed_mem[wr_ptr[PW-1:0]] <= bus.txn_is_signed;
            mask_mem[wr_ptr[PW-1:0]]   <= bus.txn_col_mask;
            last_mem[wr_ptr[PW-1:0]]   <= bus.txn_is_last;
        end
    end

    // FIFO pointers and head-transaction beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (beat_acc) beat_cnt <= at_end ? '0 : beat_cnt + 1'b1;
        end
    end

    // output row register: load on accepted beat, drain on row_ready, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            row_valid_q <= 1'b0;
            row_q       <= '0;
            row_last_q  <= 1'b0;
        end else if (beat_acc) begin
            row_valid_q <= 1'b1;
            row_q       <= next_row;
            row_last_q  <= head_last & at_end;
        end else if (bus.row_ready) begin
            row_valid_q <= 1'b0;
        end
    end

`ifdef DCA_RDATA_UNFORMAT_RLAST_CHECK_EN
    // sticky flag: RLAST disagreed with the alen-derived burst end
    always_ff @(posedge clk) begin
        if (rst)                                      err_rlast <= 1'b0;
        else if (beat_acc && (bus.rdata_last != at_end)) err_rlast <= 1'b1;
    end
`else
    logic unused_rlast;
    assign unused_rlast = bus.rdata_last;
`endif
endmodule

// File: tb/tb_dca_matrix_lsu_rdata_unformatter.sv
// Self-checking bench for dca_matrix_lsu_rdata_unformatter.
// Expected rows are queued when beats are driven and compared as rows leave.
module tb_dca_matrix_lsu_rdata_unformatter;
    localparam int NC = 4, BS = 8, BE = 32, BA = 8, TD = 4;

    typedef struct {
        logic [NC*BE-1:0] d;
        logic             l;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    logic [$clog2(TD):0] txn_count;
    logic busy;
`ifdef DCA_RDATA_UNFORMAT_RLAST_CHECK_EN
    logic err_rlast;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int rows_seen = 0;
    row_t exp_q[$];

    dca_matrix_lsu_rdata_unformatter_if #(.NUM_COL(NC), .BW_SCALAR(BS), .BW_ELEMENT(BE), .BW_ALEN(BA)) bus ();

    dca_matrix_lsu_rdata_unformatter #(
        .NUM_COL(NC), .BW_SCALAR(BS), .BW_ELEMENT(BE), .BW_ALEN(BA), .TXN_DEPTH(TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .txn_count (txn_count),
`ifdef DCA_RDATA_UNFORMAT_RLAST_CHECK_EN
        .err_rlast (err_rlast),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NC*BE-1:0] obs, input logic [NC*BE-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*BE-1:0] model(input logic [NC*BS-1:0] beat, input logic sgn,
                                               input logic [NC-1:0] mask);
        logic [NC*BE-1:0] r;
        logic [BS-1:0]    s;
        logic [BE-1:0]    e;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            s = beat[BS*c +: BS];
            e = sgn ? BE'($signed(s)) : BE'(s);
            if (!mask[c]) e = '0;
            r[BE*c +: BE] = e;
        end
        return r;
    endfunction

    // scoreboard: a row leaves whenever valid & ready hold at the coming edge
    always @(negedge clk) begin
        if (bus.row_valid && bus.row_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_row", 1, 0);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                chk("row_data", bus.row_data, e.d);
                chk("row_last", {127'b0, bus.row_last}, {127'b0, e.l});
            end
            rows_seen++;
        end
    end

    task automatic push_txn(input logic [BA-1:0] alen, input logic sgn, input logic [NC-1:0] mask,
                            input logic last);
        logic r;
        bus.txn_valid = 1'b1; bus.txn_alen = alen; bus.txn_is_signed = sgn;
        bus.txn_col_mask = mask; bus.txn_is_last = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); r = bus.txn_ready;
            @(posedge clk); #1;
            if (r) break;
            if (i == 19) chk("push_timeout", 0, 1);
        end
        bus.txn_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [NC*BS-1:0] data, input logic rl,
                             input logic [NC*BE-1:0] ed, input logic el);
        logic r;
        row_t e;
        bus.rdata_valid = 1'b1; bus.rdata_data = data; bus.rdata_last = rl;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); r = bus.rdata_ready;
            @(posedge clk); #1;
            if (r) break;
            if (i == 19) chk("beat_timeout", 0, 1);
        end
        e.d = ed; e.l = el;
        exp_q.push_back(e);
        bus.rdata_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [NC*BS-1:0] d;
        logic [NC*BE-1:0] held;
        logic [NC-1:0]    masks [4];
        logic             sgns  [4];
        logic [NC*BS-1:0] datas [4];
        int               base;

        rst = 1'b1;
        bus.txn_valid = 0; bus.txn_alen = 0; bus.txn_is_signed = 0; bus.txn_col_mask = 0;
        bus.txn_is_last = 0; bus.rdata_valid = 0; bus.rdata_data = 0; bus.rdata_last = 0;
        bus.row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_row_valid", bus.row_valid, 0);
        chk("rst_row_data", bus.row_data, 0);
        chk("rst_row_last", bus.row_last, 0);
        chk("rst_txn_count", txn_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn_ready", bus.txn_ready, 1);
        chk("rst_rdata_ready", bus.rdata_ready, 0);
        @(posedge clk); #1;

        // signed, all columns, 4-beat burst
        push_txn(8'd3, 1'b1, 4'b1111, 1'b1);
        chk("t1_count", txn_count, 1);
        chk("t1_busy", busy, 1);
        for (int b = 0; b < 4; b++)
            send_beat(32'h010101FF, b == 3,
                      {32'h00000001, 32'h00000001, 32'h00000001, 32'hFFFFFFFF}, b == 3);
        drain();
        chk("t1_count_end", txn_count, 0);

        // unsigned with column mask
        push_txn(8'd3, 1'b0, 4'b0101, 1'b1);
        for (int b = 0; b < 4; b++)
            send_beat(32'h010101FF, b == 3,
                      {32'h00000000, 32'h00000001, 32'h00000000, 32'h000000FF}, b == 3);
        drain();
        chk("t2_count_end", txn_count, 0);

        // fill FIFO with four single-beat transactions
        for (int t = 0; t < 4; t++) begin
            masks[t] = 4'b0001 << t | 4'b1000 >> t;
            sgns[t]  = t[0];
            datas[t] = $urandom() | 32'h80808080;
            push_txn(8'd0, sgns[t], masks[t], t == 3);
        end
        chk("full_count", txn_count, 4);
        chk("full_txn_ready", bus.txn_ready, 0);
        // push attempt concurrent with a pop while full must be refused
        bus.txn_valid = 1'b1; bus.txn_alen = 8'd5; bus.txn_is_signed = 0;
        bus.txn_col_mask = 4'hF; bus.txn_is_last = 0;
        send_beat(datas[0], 1'b1, model(datas[0], sgns[0], masks[0]), 1'b0);
        bus.txn_valid = 1'b0;
        chk("full_push_refused", txn_count, 3);
        for (int t = 1; t < 4; t++)
            send_beat(datas[t], 1'b1, model(datas[t], sgns[t], masks[t]), t == 3);
        drain();
        chk("full_count_end", txn_count, 0);
        chk("full_busy_end", busy, 0);

        // back-pressure mid-burst, alen=7
        base = rows_seen;
        push_txn(8'd7, 1'b1, 4'b1011, 1'b0);
        for (int b = 0; b < 3; b++) begin
            d = $urandom();
            send_beat(d, b == 7, model(d, 1'b1, 4'b1011), 1'b0);
        end
        bus.row_ready = 1'b0;
        d = $urandom();
        bus.rdata_valid = 1'b1; bus.rdata_data = d;
        @(negedge clk);
        held = bus.row_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rdata_ready", bus.rdata_ready, 0);
            chk("stall_row_valid", bus.row_valid, 1);
            chk("stall_row_data", bus.row_data, held);
        end
        @(posedge clk); #1;
        bus.row_ready = 1'b1;
        send_beat(d, 1'b0, model(d, 1'b1, 4'b1011), 1'b0);
        for (int b = 4; b < 8; b++) begin
            d = $urandom();
            send_beat(d, b == 7, model(d, 1'b1, 4'b1011), 1'b0);
        end
        drain();
        chk("stall_row_total", rows_seen - base, 8);

        // reset at beat 2 of a 4-beat burst
        push_txn(8'd3, 1'b0, 4'b1111, 1'b1);
        for (int b = 0; b < 2; b++) begin
            d = $urandom();
            send_beat(d, 1'b0, model(d, 1'b0, 4'b1111), 1'b0);
        end
        bus.rdata_valid = 1'b1; bus.rdata_data = $urandom();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.rdata_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_row_valid", bus.row_valid, 0);
        chk("rst_mid_count", txn_count, 0);
        chk("rst_mid_rdata_ready", bus.rdata_ready, 0);
        chk("rst_mid_q_empty", exp_q.size(), 0);
        @(posedge clk); #1;

`ifdef DCA_RDATA_UNFORMAT_RLAST_CHECK_EN
        chk("err_rlast_clear", err_rlast, 0);
        base = rows_seen;
        push_txn(8'd1, 1'b1, 4'b1111, 1'b1);
        d = $urandom();
        send_beat(d, 1'b1, model(d, 1'b1, 4'b1111), 1'b0);
        chk("err_rlast_set", err_rlast, 1);
        d = $urandom();
        send_beat(d, 1'b1, model(d, 1'b1, 4'b1111), 1'b1);
        drain();
        chk("err_rlast_sticky", err_rlast, 1);
        chk("err_rlast_rows", rows_seen - base, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dca_matrix_lsu_rdata_unformatter.md
Name: dca_matrix_lsu_rdata_unformatter

Overview:
- Read-path unformatter for the DCA matrix LSU.
- Queues per-AXI-transaction info (burst length, signedness, column mask, instruction-last flag) in a small FIFO.
- Consumes AXI read-data beats, one tensor row per beat, and splits each row into NUM_COL scalars.
- Sign- or zero-extends each scalar to LSU element width, zeroes masked columns, and emits LSU element rows through a registered valid/ready stage.
- Sits between the AXI R channel and the matrix load buffer; successor to the combinational single-transaction unformatter, adding multi-transaction queueing, burst tracking, extension modes and back-pressure.

Parameters:
- NUM_COL, 4, scalars per row (matrix columns).
- BW_SCALAR, 8, bits per scalar in the AXI beat.
- BW_ELEMENT, 32, bits per LSU element; must be >= BW_SCALAR.
- BW_ALEN, 8, AXI burst length field width.
- TXN_DEPTH, 4, transaction-info FIFO depth; power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- txn_valid  input  1  transaction info valid.
- txn_ready  output  1  FIFO not full.
- txn_alen  input  BW_ALEN  beats minus one.
- txn_is_signed  input  1  1 = sign-extend, 0 = zero-extend.
- txn_col_mask  input  NUM_COL  1 = column enabled.
- txn_is_last  input  1  final transaction of the instruction.
- rdata_valid  input  1  AXI R beat valid.
- rdata_ready  output  1  beat accepted this cycle.
- rdata_data  input  NUM_COL*BW_SCALAR  beat payload; column i at [BW_SCALAR*i +: BW_SCALAR].
- rdata_last  input  1  AXI RLAST.
- row_valid  output  1  element row valid.
- row_ready  input  1  downstream accepts.
- row_data  output  NUM_COL*BW_ELEMENT  column i at [BW_ELEMENT*i +: BW_ELEMENT].
- row_last  output  1  last row of the instruction.
- txn_count  output  clog2(TXN_DEPTH)+1  FIFO occupancy.
- busy  output  1  FIFO non-empty or row_valid.

Behaviour:
- Reset (synchronous, active-high): clears FIFO pointers and beat_cnt. row_valid=0, row_data=0, row_last=0, txn_count=0, busy=0; txn_ready=1 from the first cycle after reset.
- Reset asserted mid-burst discards all queued info and any pending row; no partial state survives.
- txn push:
  - txn_ready = !full. Ready does not consider a same-cycle pop, so a push is refused when full even if a pop occurs.
  - Push and pop in the same cycle (not full, not empty) leave txn_count unchanged.
- Head transaction fields drive unformatting; beat_cnt (BW_ALEN bits) counts accepted beats of the head transaction.
- rdata_ready = fifo_nonempty & (!row_valid | row_ready). With the FIFO empty, beats stall.
- On an accepted beat:
  - row register loads next edge; latency is 1 cycle.
  - For each column i: if col_mask[i]=0, the element is 0. Otherwise the scalar is extended to BW_ELEMENT, sign-extended when is_signed=1 and zero-extended when is_signed=0. If BW_ELEMENT==BW_SCALAR the scalar passes unchanged.
  - row_last = is_last & (beat_cnt==alen).
  - If beat_cnt==alen: pop FIFO, beat_cnt<=0. Otherwise beat_cnt<=beat_cnt+1.
- Output register:
  - Holds all outputs stable while row_valid & !row_ready.
  - Clears row_valid on row_ready when no new beat is accepted.
  - Back-to-back throughput is one row per cycle when row_ready is held at 1.
- alen=0: a single beat pops the transaction immediately.
- rdata_last is ignored unless the optional feature is compiled in; burst end is determined solely by alen.

Optional Feature:
- Macro: DCA_RDATA_UNFORMAT_RLAST_CHECK_EN.
- With the macro defined:
  - Adds output port err_rlast (1 bit).
  - err_rlast is sticky; it is set on any accepted beat where rdata_last != (beat_cnt==alen).
  - Cleared only by rst.
  - Datapath behaviour is unchanged; beat counting still follows alen.
- Without the macro: port absent, rdata_last unused.

Test Plan:
- Push {alen=3, signed=1, mask=4'b1111, last=1}; 4 beats with column0=8'hFF, others 8'h01; row_ready=1 -> 4 rows, column0=32'hFFFFFFFF, others 32'h00000001; row_last only on the 4th row; txn_count returns to 0.
- Same transaction with signed=0 and mask=4'b0101 -> column0=32'h000000FF, column2=32'h00000001, columns 1 and 3 = 0.
- Push 4 transactions, alen=0 each -> txn_ready=0 on the 5th push attempt; push while popping when full is refused; 4 single-beat rows emitted in order.
- row_ready=0 for 5 cycles mid-burst -> row_data stable, rdata_ready=0; after release, no beat lost or duplicated (alen=7 yields exactly 8 rows).
- Assert rst at beat 2 of an alen=3 transaction -> next cycle row_valid=0, txn_count=0, rdata_ready=0.
- With DCA_RDATA_UNFORMAT_RLAST_CHECK_EN defined: alen=1, rdata_last=1 on beat 0 -> err_rlast=1 and stays 1; both rows are still emitted.
